// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, line constants and default bit timing.
// Used by the transmitter; the UART_TX_PARITY_EN build adds the PARITY state to the sequence.
package uart_pkg;

  localparam int unsigned UART_CLK_DIV_DEFAULT = 5200;
  localparam int unsigned UART_DATA_BITS       = 8;
  localparam int unsigned UART_BIT_IDX_W       = $clog2(UART_DATA_BITS);
  localparam logic        UART_IDLE_LEVEL      = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Even parity over one data byte.
  function automatic logic uart_even_parity(input logic [UART_DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period divider: counts 0..CLK_DIV-1 while enabled and pulses tick on the wrap cycle.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV = UART_CLK_DIV_DEFAULT
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             at_max;

  assign at_max = (cnt_q == CNT_MAX);
  // Clear wins so a new frame always starts a full period from the acceptance edge.
  assign tick   = enable && !clear && at_max;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = at_max ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter with start/busy handshake, LSB-first serialisation and a done pulse.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV = UART_CLK_DIV_DEFAULT
) (
  input  logic                      sys_clk,
  input  logic                      rst_n,
  input  logic [UART_DATA_BITS-1:0] TX_data,
  input  logic                      TX_start,
  output logic                      TX_busy,
  output logic                      TX_done,
  output logic                      UART_Tx
);

  localparam logic [UART_BIT_IDX_W-1:0] LAST_IDX = UART_BIT_IDX_W'(UART_DATA_BITS - 1);

  uart_state_e               state_q;
  uart_state_e               state_d;
  logic [UART_DATA_BITS-1:0] shift_q;
  logic [UART_DATA_BITS-1:0] shift_d;
  logic [UART_BIT_IDX_W-1:0] bit_idx_q;
  logic [UART_BIT_IDX_W-1:0] bit_idx_d;
  logic                      tx_q;
  logic                      tx_d;
  logic                      busy_q;
  logic                      busy_d;
  logic                      done_q;
  logic                      done_d;
`ifdef UART_TX_PARITY_EN
  logic                      parity_q;
  logic                      parity_d;
`endif

  logic accept_c;
  logic baud_en_c;
  logic tick;

  assign accept_c  = !busy_q && TX_start;
  assign baud_en_c = (state_q != ST_IDLE);

  uart_baud_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_baud_tick (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .clear   (accept_c),
    .enable  (baud_en_c),
    .tick    (tick)
  );

  // Next-state and next-line-level logic; every line change happens on a tick or on acceptance.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          state_d   = ST_START;
          shift_d   = TX_data;
          bit_idx_d = '0;
          tx_d      = 1'b0;
          busy_d    = 1'b1;
`ifdef UART_TX_PARITY_EN
          parity_d  = uart_even_parity(TX_data);
`endif
        end
      end

      ST_START: begin
        if (tick) begin
          state_d = ST_DATA;
          tx_d    = shift_q[0];
        end
      end

      ST_DATA: begin
        if (tick) begin
          if (bit_idx_q == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
            tx_d    = parity_q;
`else
            state_d = ST_STOP;
            tx_d    = UART_IDLE_LEVEL;
`endif
          end else begin
            // shift_q[0] is on the line; the next bit is already waiting in shift_q[1].
            bit_idx_d = bit_idx_q + UART_BIT_IDX_W'(1);
            shift_d   = {1'b0, shift_q[UART_DATA_BITS-1:1]};
            tx_d      = shift_q[1];
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          state_d = ST_STOP;
          tx_d    = UART_IDLE_LEVEL;
        end
      end
`endif

      ST_STOP: begin
        if (tick) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        tx_d    = UART_IDLE_LEVEL;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      tx_q      <= UART_IDLE_LEVEL;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign UART_Tx = tx_q;
  assign TX_busy = busy_q;
  assign TX_done = done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed self-checking bench for uart_transmitter at CLK_DIV=16 (parity cases under UART_TX_PARITY_EN).
module tb_uart_transmitter;

  localparam int D  = 16;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int FL = FB * D;

  logic       sys_clk = 1'b0;
  logic       rst_n;
  logic [7:0] TX_data;
  logic       TX_start;
  logic       TX_busy;
  logic       TX_done;
  logic       UART_Tx;

  int tests = 0;
  int fails = 0;

  uart_transmitter #(
    .CLK_DIV (D)
  ) dut (
    .sys_clk  (sys_clk),
    .rst_n    (rst_n),
    .TX_data  (TX_data),
    .TX_start (TX_start),
    .TX_busy  (TX_busy),
    .TX_done  (TX_done),
    .UART_Tx  (UART_Tx)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Line levels of one frame, index 0 = start bit.
  function automatic logic [FB-1:0] frame_of(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
    return {1'b1, ^d, d, 1'b0};
`else
    return {1'b1, d, 1'b0};
`endif
  endfunction

  // Caller sets TX_data/TX_start before calling; cycle i counts from the acceptance edge.
  task automatic run_frame(input logic [7:0] d, input logic [7:0] next_data, input int window,
                           input int pulse_at, input bit hold,
                           output int errs, output logic [FB-1:0] mids,
                           output int busy_n, output int done_n);
    logic [FB-1:0] fr;
    logic [FB-1:0] fr_sh;
    logic          exp_tx;
    logic          exp_busy;
    logic          exp_done;
    fr     = frame_of(d);
    errs   = 0;
    busy_n = 0;
    done_n = 0;
    mids   = '0;
    @(posedge sys_clk);
    for (int i = 0; i < window; i++) begin
      @(negedge sys_clk);
      if (i == 0) begin
        TX_data = next_data;
        if (!hold) TX_start = 1'b0;
      end
      if (pulse_at >= 0 && i == pulse_at) begin
        TX_start = 1'b1;
        TX_data  = 8'hFF;
      end
      if (pulse_at >= 0 && i == pulse_at + 1) TX_start = 1'b0;
      fr_sh    = fr >> (i / D);
      exp_tx   = (i < FL) ? fr_sh[0] : 1'b1;
      exp_busy = (i < FL);
      exp_done = (i == FL);
      if (UART_Tx !== exp_tx || TX_busy !== exp_busy || TX_done !== exp_done) errs++;
      if (TX_busy === 1'b1) busy_n++;
      if (TX_done === 1'b1) done_n++;
      if (i < FL && (i % D) == D / 2) mids = mids | (FB'(UART_Tx) << (i / D));
    end
  endtask

  int            errs;
  int            busy_n;
  int            done_n;
  int            bad;
  logic [FB-1:0] mids;
  logic [FB-1:0] exp_frame;

  initial begin
    rst_n    = 1'b0;
    TX_start = 1'b0;
    TX_data  = 8'h00;
    repeat (3) @(negedge sys_clk);
    check("rst_tx", 32'(UART_Tx), 32'(1));
    check("rst_busy", 32'(TX_busy), 32'(0));
    check("rst_done", 32'(TX_done), 32'(0));
    rst_n = 1'b1;

    bad = 0;
    repeat (100) begin
      @(negedge sys_clk);
      if (UART_Tx !== 1'b1 || TX_busy !== 1'b0 || TX_done !== 1'b0) bad++;
    end
    check("idle_100", 32'(bad), 32'(0));

    // 0x55, TX_data changed right after acceptance
    TX_data  = 8'h55;
    TX_start = 1'b1;
    run_frame(8'h55, 8'h00, FL + 8, -1, 1'b0, errs, mids, busy_n, done_n);
    exp_frame = frame_of(8'h55);
    check("f55_model", 32'(errs), 32'(0));
    check("f55_mids", 32'(mids), 32'(exp_frame));
`ifdef UART_TX_PARITY_EN
    check("f55_mids_hand", 32'(mids), 32'(11'b100_1010_1010));
`else
    check("f55_mids_hand", 32'(mids), 32'(10'b10_1010_1010));
`endif
    check("f55_busy_cycles", 32'(busy_n), 32'(FL));
    check("f55_done_cycles", 32'(done_n), 32'(1));

    // 0xA3 with a start pulse mid-frame that must be ignored
    TX_data  = 8'hA3;
    TX_start = 1'b1;
    run_frame(8'hA3, 8'hA3, FL + 40, 40, 1'b0, errs, mids, busy_n, done_n);
    exp_frame = frame_of(8'hA3);
    check("fa3_model", 32'(errs), 32'(0));
    check("fa3_mids", 32'(mids), 32'(exp_frame));
    check("fa3_busy_cycles", 32'(busy_n), 32'(FL));
    check("fa3_done_cycles", 32'(done_n), 32'(1));

    // Back-to-back with TX_start held: 0x00 then 0xFF
    TX_data  = 8'h00;
    TX_start = 1'b1;
    run_frame(8'h00, 8'hFF, FL + 1, -1, 1'b1, errs, mids, busy_n, done_n);
    exp_frame = frame_of(8'h00);
    check("b2b0_model", 32'(errs), 32'(0));
    check("b2b0_mids", 32'(mids), 32'(exp_frame));
    check("b2b_gap_tx", 32'(UART_Tx), 32'(1));
    check("b2b_gap_busy", 32'(TX_busy), 32'(0));
    run_frame(8'hFF, 8'hFF, FL + 8, -1, 1'b0, errs, mids, busy_n, done_n);
    exp_frame = frame_of(8'hFF);
    check("b2b1_model", 32'(errs), 32'(0));
    check("b2b1_mids", 32'(mids), 32'(exp_frame));
    check("b2b1_busy_cycles", 32'(busy_n), 32'(FL));

    // Reset during data bit 4 of 0x0F
    TX_data  = 8'h0F;
    TX_start = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    TX_start = 1'b0;
    repeat (84) @(negedge sys_clk);
    check("f0f_bit4_low", 32'(UART_Tx), 32'(0));
    check("f0f_bit4_busy", 32'(TX_busy), 32'(1));
    #1 rst_n = 1'b0;
    #1;
    check("midrst_tx", 32'(UART_Tx), 32'(1));
    check("midrst_busy", 32'(TX_busy), 32'(0));
    check("midrst_done", 32'(TX_done), 32'(0));
    @(negedge sys_clk);
    rst_n = 1'b1;
    repeat (3) @(negedge sys_clk);
    check("postrst_tx", 32'(UART_Tx), 32'(1));
    check("postrst_busy", 32'(TX_busy), 32'(0));
    TX_data  = 8'h81;
    TX_start = 1'b1;
    run_frame(8'h81, 8'h00, FL + 8, -1, 1'b0, errs, mids, busy_n, done_n);
    exp_frame = frame_of(8'h81);
    check("f81_model", 32'(errs), 32'(0));
    check("f81_mids", 32'(mids), 32'(exp_frame));
    check("f81_busy_cycles", 32'(busy_n), 32'(FL));

`ifdef UART_TX_PARITY_EN
    TX_data  = 8'h07;
    TX_start = 1'b1;
    run_frame(8'h07, 8'h00, FL + 8, -1, 1'b0, errs, mids, busy_n, done_n);
    check("p07_model", 32'(errs), 32'(0));
    check("p07_parity", 32'(mids[FB-2]), 32'(1));
    check("p07_busy_cycles", 32'(busy_n), 32'(176));
    TX_data  = 8'h03;
    TX_start = 1'b1;
    run_frame(8'h03, 8'h00, FL + 8, -1, 1'b0, errs, mids, busy_n, done_n);
    check("p03_model", 32'(errs), 32'(0));
    check("p03_parity", 32'(mids[FB-2]), 32'(0));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
